// File: rtl/key_event_encoder_pkg.sv
// key_event_encoder_pkg: shared event encoding and drop-counter constants
package key_event_encoder_pkg;
  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;
  localparam int   DROP_STEP   = 2;
  localparam int   DROP_MAX    = 255;
endpackage

// File: rtl/key_event_encoder_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-count debouncer for one sensor line
module key_debounce
  import key_event_encoder_pkg::*;
#(
  parameter int DB_COUNT = 16,
  parameter int DBW      = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic flip
);
  logic s1_q, s2_q, level_q;
  logic [DBW-1:0] cnt_q, cnt_d;
  assign flip  = (s2_q != level_q) && (cnt_q == DBW'(DB_COUNT - 1));
  assign level = level_q;
  // count consecutive cycles the synced level disagrees with the accepted level
  always_comb cnt_d = (s2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
  // synchroniser, counter and accepted level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_q ^ flip;
      cnt_q   <= cnt_d;
    end
endmodule

// File: rtl/key_event_encoder.sv
// key_event_encoder: debounced key press/release events, round-robin written into a FIFO
module key_event_encoder
  import key_event_encoder_pkg::*;
#(
  parameter int NKEYS    = 8,
  parameter int KEYW     = 3,
  parameter int DB_COUNT = 16,
  parameter int DBW      = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] sensor_in,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [KEYW:0]    fifo_din,
  output logic [NKEYS-1:0] key_state,
  output logic             busy,
  output logic [7:0]       drop_count
);
  logic [NKEYS-1:0] flip, pending_q, pending_d;
  logic [KEYW-1:0]  rr_q, rr_d, idx, jj;
  logic             grant, fifo_wr_q;
  logic [KEYW:0]    fifo_din_q, fifo_din_d;
  logic [7:0]       drop_q, drop_d;
  int               cancels, tot;
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(.DB_COUNT(DB_COUNT), .DBW(DBW)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sensor_in[i]),
      .level  (key_state[i]),
      .flip   (flip[i])
    );
  end
  // pick the first pending key at or after rr_q, wrapping; nothing while full
  always_comb begin
    grant = 1'b0;
    idx   = '0;
    jj    = '0;
    for (int k = 0; k < NKEYS; k++) begin
      jj = KEYW'((int'(rr_q) + k) % NKEYS);
      if (!fifo_full && !grant && pending_q[jj]) begin
        grant = 1'b1;
        idx   = jj;
      end
    end
    rr_d       = grant ? ((idx == KEYW'(NKEYS - 1)) ? '0 : idx + 1'b1) : rr_q;
    fifo_din_d = grant ? {key_state[idx], idx} : fifo_din_q;
  end
  // emission clears first, so a same-cycle flip re-arms the key; a flip on a still-pending key cancels both
  always_comb begin
    pending_d = pending_q;
    cancels   = 0;
    if (grant) pending_d[idx] = 1'b0;
    for (int k = 0; k < NKEYS; k++)
      if (flip[k]) begin
        if (pending_d[k]) cancels++;
        pending_d[k] = ~pending_d[k];
      end
    tot    = int'(drop_q) + DROP_STEP * cancels;
    drop_d = (tot > DROP_MAX) ? 8'(DROP_MAX) : 8'(tot);
  end
  // pending vector, arbiter pointer, output register and drop counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending_q  <= '0;
      rr_q       <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_din_q <= '0;
      drop_q     <= '0;
    end else begin
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      fifo_wr_q  <= grant;
      fifo_din_q <= fifo_din_d;
      drop_q     <= drop_d;
    end
  assign fifo_wr    = fifo_wr_q;
  assign fifo_din   = fifo_din_q;
  assign busy       = |pending_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder: table-driven, hand-sequence and randomized checks against a behavioural model
module tb_key_event_encoder;
  localparam int NKEYS = 8;
  localparam int DB    = 16;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sensor_in = '0;
  logic       fifo_full = 1'b0;
  logic       fifo_wr;
  logic [3:0] fifo_din;
  logic [7:0] key_state;
  logic       busy;
  logic [7:0] drop_count;
  int total = 0;
  int bad = 0;
  key_event_encoder #(.NKEYS(8), .KEYW(3), .DB_COUNT(16), .DBW(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sensor_in (sensor_in),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .key_state (key_state),
    .busy      (busy),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  // behavioural model: per-key sample history, disagreement run length, outstanding-event flags
  int         m_hist1[NKEYS], m_hist2[NKEYS], m_state[NKEYS], m_run[NKEYS], m_pend[NKEYS];
  int         m_rr, m_drop, m_wr, m_din;
  int         wr_seen;
  logic [3:0] last_din;
  typedef struct {
    logic [7:0] sens;
    logic       full;
    int         ncyc;
    logic [7:0] ks;
    logic       bsy;
    int         drop;
    int         wrs;
    logic [3:0] din;
  } vec_t;
  vec_t tbl[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < NKEYS; k++) begin
      m_hist1[k] = 0;
      m_hist2[k] = 0;
      m_state[k] = 0;
      m_run[k]   = 0;
      m_pend[k]  = 0;
    end
    m_rr   = 0;
    m_drop = 0;
    m_wr   = 0;
    m_din  = 0;
  endtask
  function automatic logic [7:0] pack(input int a[NKEYS]);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < NKEYS; k++) v[k] = (a[k] != 0);
    return v;
  endfunction
  task automatic model_step();
    int sel;
    int any;
    sel = -1;
    any = 0;
    for (int k = 0; k < NKEYS; k++) any += m_pend[k];
    if (!fifo_full && any != 0)
      for (int k = 0; k < NKEYS; k++)
        if (sel < 0 && m_pend[(m_rr + k) % NKEYS] != 0) sel = (m_rr + k) % NKEYS;
    m_wr = (sel >= 0) ? 1 : 0;
    if (sel >= 0) begin
      m_din      = m_state[sel] * 8 + sel;
      m_pend[sel] = 0;
      m_rr       = (sel + 1) % NKEYS;
    end
    for (int k = 0; k < NKEYS; k++) begin
      m_run[k] = (m_hist2[k] != m_state[k]) ? m_run[k] + 1 : 0;
      if (m_run[k] == DB) begin
        m_run[k]   = 0;
        m_state[k] = 1 - m_state[k];
        if (m_pend[k] != 0) begin
          m_pend[k] = 0;
          m_drop    = (m_drop + 2 > 255) ? 255 : m_drop + 2;
        end else m_pend[k] = 1;
      end
      m_hist2[k] = m_hist1[k];
      m_hist1[k] = sensor_in[k] ? 1 : 0;
    end
  endtask
  task automatic tick();
    logic [7:0] ps;
    logic [7:0] st;
    @(posedge clk);
    model_step();
    #1;
    ps = pack(m_pend);
    st = pack(m_state);
    check("model", 32'({fifo_wr, fifo_din, key_state, busy, drop_count}),
          32'({m_wr[0], m_din[3:0], st, |ps, m_drop[7:0]}));
    if (fifo_wr) begin
      wr_seen++;
      last_din = fifo_din;
    end
  endtask
  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    check("reset_outputs", 32'({fifo_wr, fifo_din, key_state, busy, drop_count}), 32'd0);
    @(posedge clk);
    #4;
    model_reset();
    reset_n = 1'b1;
  endtask
  task automatic add(input logic [7:0] s, input logic f, input int n, input logic [7:0] ks,
                     input logic b, input int d, input int w, input logic [3:0] din);
    vec_t v;
    v.sens = s; v.full = f; v.ncyc = n; v.ks = ks; v.bsy = b; v.drop = d; v.wrs = w; v.din = din;
    tbl.push_back(v);
  endtask
  initial begin
    int n;
    add(8'h04, 1'b0, 17, 8'h00, 1'b0, 0, 0, 4'h0);
    add(8'h04, 1'b0,  1, 8'h04, 1'b1, 0, 0, 4'h0);
    add(8'h04, 1'b0,  1, 8'h04, 1'b0, 0, 1, 4'b1010);
    add(8'h24, 1'b0, 10, 8'h04, 1'b0, 0, 0, 4'h0);
    add(8'h04, 1'b0, 30, 8'h04, 1'b0, 0, 0, 4'h0);
    add(8'h05, 1'b1, 20, 8'h05, 1'b1, 0, 0, 4'h0);
    add(8'h04, 1'b1, 20, 8'h04, 1'b0, 2, 0, 4'h0);
    add(8'h04, 1'b0,  3, 8'h04, 1'b0, 2, 0, 4'h0);
    add(8'h84, 1'b1, 20, 8'h84, 1'b1, 2, 0, 4'h0);
    add(8'h84, 1'b0,  1, 8'h84, 1'b0, 2, 1, 4'b1111);
    add(8'h8C, 1'b0, 19, 8'h8C, 1'b0, 2, 1, 4'b1011);
    add(8'h84, 1'b0, 19, 8'h84, 1'b0, 2, 1, 4'b0011);
    add(8'hCE, 1'b0, 18, 8'hCE, 1'b1, 2, 0, 4'h0);
    add(8'hCE, 1'b0,  1, 8'hCE, 1'b1, 2, 1, 4'b1110);
    add(8'hCE, 1'b0,  1, 8'hCE, 1'b1, 2, 1, 4'b1001);
    add(8'hCE, 1'b0,  1, 8'hCE, 1'b0, 2, 1, 4'b1011);
    model_reset();
    #3;
    pulse_reset();
    foreach (tbl[i]) begin
      sensor_in = tbl[i].sens;
      fifo_full = tbl[i].full;
      wr_seen   = 0;
      repeat (tbl[i].ncyc) tick();
      check($sformatf("vec%0d key_state", i), 32'(key_state), 32'(tbl[i].ks));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(tbl[i].drop));
      check($sformatf("vec%0d writes", i), 32'(wr_seen), 32'(tbl[i].wrs));
      if (tbl[i].wrs > 0) check($sformatf("vec%0d fifo_din", i), 32'(last_din), 32'(tbl[i].din));
    end
    sensor_in = 8'h84;
    fifo_full = 1'b1;
    repeat (18) tick();
    check("three_pending_busy", 32'(busy), 32'd1);
    pulse_reset();
    fifo_full = 1'b0;
    wr_seen   = 0;
    repeat (25) tick();
    check("post_reset_writes", 32'(wr_seen), 32'd2);
    check("post_reset_last_din", 32'(last_din), 32'b1111);
    check("post_reset_key_state", 32'(key_state), 32'h84);
    check("post_reset_drop", 32'(drop_count), 32'd0);
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 3) == 0) sensor_in = 8'($urandom);
      else sensor_in = sensor_in ^ 8'(1 << $urandom_range(0, 7));
      fifo_full = ($urandom_range(0, 3) == 0);
      n = int'($urandom_range(1, 40));
      repeat (n) tick();
      if ($urandom_range(0, 60) == 0) pulse_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
